// File: rtl/vcxo_lock_monitor.sv
// vcxo_lock_monitor: lock/holdover supervision, PWM rail fault, error statistics and snapshot handshake
// for the VCXO frequency-correction loop, all in the TCXO clock domain.
module vcxo_lock_monitor #(
    parameter int LOCK_TOL    = 2,
    parameter int UNLOCK_TOL  = 20,
    parameter int LOCK_TIME   = 3686400,
    parameter int UNLOCK_TIME = 1228800,
    parameter int RAIL_TIME   = 1228800,
    parameter int PWM_MAX     = 32000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [31:0] freq_error,
    input  logic [23:0] PWM,
    input  logic        clear_stats_in,
    input  logic        snap_req_in,
    input  logic        snap_ack_in,
    output logic        locked_out,
    output logic        rail_fault_out,
    output logic [1:0]  lock_state_out,
    output logic        snap_valid_out,
    output logic [63:0] snap_data_out
);
    localparam logic [1:0] S_UNLOCKED  = 2'd0;
    localparam logic [1:0] S_ACQUIRING = 2'd1;
    localparam logic [1:0] S_LOCKED    = 2'd2;
    localparam logic [1:0] S_HOLDOVER  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_timer;
    logic [31:0] r_rail_cnt;
    logic        r_rail_fault;
    logic [15:0] r_err_min;
    logic [15:0] r_err_max;
    logic        r_snap_valid;
    logic [63:0] r_snap_data;

    logic [32:0] w_err_ext;
    logic [32:0] w_abs_err;
    logic        w_in_lock;
    logic        w_in_unlock;
    logic [1:0]  w_state_nx;
    logic [31:0] w_timer_nx;
    logic [15:0] w_sat;
    logic        w_at_rail;
    logic [31:0] w_rail_nx;

    // 33-bit magnitude so that -2^31 maps to +2^31 without overflow
    assign w_err_ext   = {freq_error[31], freq_error};
    assign w_abs_err   = freq_error[31] ? -w_err_ext : w_err_ext;
    assign w_in_lock   = w_abs_err <= 33'(LOCK_TOL);
    assign w_in_unlock = w_abs_err <= 33'(UNLOCK_TOL);

    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        case (r_state)
            S_UNLOCKED: begin
                if (w_in_lock) begin
                    w_state_nx = S_ACQUIRING;
                    w_timer_nx = 32'd1;
                end
            end
            S_ACQUIRING: begin
                if (!w_in_lock) begin
                    w_state_nx = S_UNLOCKED;
                    w_timer_nx = 32'd0;
                end else if (r_timer == 32'(LOCK_TIME - 1)) begin
                    w_state_nx = S_LOCKED;
                    w_timer_nx = 32'd0;
                end else begin
                    w_timer_nx = r_timer + 32'd1;
                end
            end
            S_LOCKED: begin
                if (!w_in_unlock) begin
                    w_state_nx = S_HOLDOVER;
                    w_timer_nx = 32'd1;
                end
            end
            default: begin
                if (w_in_unlock) begin
                    w_state_nx = S_LOCKED;
                    w_timer_nx = 32'd0;
                end else if (r_timer == 32'(UNLOCK_TIME - 1)) begin
                    w_state_nx = S_UNLOCKED;
                    w_timer_nx = 32'd0;
                end else begin
                    w_timer_nx = r_timer + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= S_UNLOCKED;
            r_timer <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
        end
    end

    // In range when bits 31..15 are all equal, otherwise clamp by sign
    assign w_sat = (&freq_error[31:15] || ~|freq_error[31:15]) ? freq_error[15:0] :
                   freq_error[31] ? 16'h8000 : 16'h7fff;

    always_ff @(posedge clk_in) begin
        if (reset_in || clear_stats_in) begin
            r_err_min <= w_sat;
            r_err_max <= w_sat;
        end else begin
            r_err_min <= ($signed(w_sat) < $signed(r_err_min)) ? w_sat : r_err_min;
            r_err_max <= ($signed(w_sat) > $signed(r_err_max)) ? w_sat : r_err_max;
        end
    end

    assign w_at_rail = ($signed(PWM) <= 24'sd1) || ($signed(PWM) >= $signed(24'(PWM_MAX)));
    assign w_rail_nx = w_at_rail ? (&r_rail_cnt ? r_rail_cnt : r_rail_cnt + 32'd1) : 32'd0;

    always_ff @(posedge clk_in) begin
        if (reset_in || clear_stats_in) begin
            r_rail_cnt   <= 32'd0;
            r_rail_fault <= 1'b0;
        end else begin
            r_rail_cnt   <= w_rail_nx;
            r_rail_fault <= r_rail_fault || (w_rail_nx == 32'(RAIL_TIME));
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_snap_valid <= 1'b0;
            r_snap_data  <= 64'd0;
        end else if (!r_snap_valid && snap_req_in) begin
            r_snap_valid <= 1'b1;
            r_snap_data  <= {r_state, r_rail_fault, 5'b0, PWM, r_err_min, r_err_max};
        end else if (r_snap_valid && snap_ack_in) begin
            r_snap_valid <= 1'b0;
        end
    end

    assign locked_out     = r_state[1];
    assign lock_state_out = r_state;
    assign rail_fault_out = r_rail_fault;
    assign snap_valid_out = r_snap_valid;
    assign snap_data_out  = r_snap_data;
endmodule

// File: tb/tb_vcxo_lock_monitor.sv
// tb_vcxo_lock_monitor: directed vectors with hand-computed expectations for vcxo_lock_monitor.
module tb_vcxo_lock_monitor;
    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic [31:0] freq_error = 32'd100;
    logic [23:0] PWM = 24'd1000;
    logic        clear_stats_in = 1'b0;
    logic        snap_req_in = 1'b0;
    logic        snap_ack_in = 1'b0;
    logic        locked_out;
    logic        rail_fault_out;
    logic [1:0]  lock_state_out;
    logic        snap_valid_out;
    logic [63:0] snap_data_out;
    int          n_cmp = 0;
    int          n_err = 0;

    vcxo_lock_monitor #(
        .LOCK_TOL(2), .UNLOCK_TOL(20), .LOCK_TIME(8),
        .UNLOCK_TIME(4), .RAIL_TIME(6), .PWM_MAX(32000)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .freq_error(freq_error), .PWM(PWM),
        .clear_stats_in(clear_stats_in), .snap_req_in(snap_req_in), .snap_ack_in(snap_ack_in),
        .locked_out(locked_out), .rail_fault_out(rail_fault_out), .lock_state_out(lock_state_out),
        .snap_valid_out(snap_valid_out), .snap_data_out(snap_data_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        repeat (2) tick();
        check("rst_locked", 64'(locked_out), 64'd0);
        check("rst_state", 64'(lock_state_out), 64'd0);
        check("rst_fault", 64'(rail_fault_out), 64'd0);
        check("rst_valid", 64'(snap_valid_out), 64'd0);
        check("rst_data", snap_data_out, 64'd0);
        reset_in = 1'b0;
        tick();
        check("idle_state", 64'(lock_state_out), 64'd0);
        // acquisition with an interruption
        freq_error = 32'd0;
        tick();
        check("acq_start", 64'(lock_state_out), 64'd1);
        repeat (3) tick();
        check("acq_mid", 64'(lock_state_out), 64'd1);
        freq_error = 32'd3;
        tick();
        check("acq_abort", 64'(lock_state_out), 64'd0);
        freq_error = 32'd0;
        repeat (7) tick();
        check("acq_7_state", 64'(lock_state_out), 64'd1);
        check("acq_7_locked", 64'(locked_out), 64'd0);
        tick();
        check("lock_state", 64'(lock_state_out), 64'd2);
        check("lock_locked", 64'(locked_out), 64'd1);
        // hysteresis
        freq_error = 32'd15;
        repeat (3) tick();
        check("hyst_15", 64'(lock_state_out), 64'd2);
        freq_error = -32'sd21;
        repeat (3) tick();
        check("hold_state", 64'(lock_state_out), 64'd3);
        check("hold_locked", 64'(locked_out), 64'd1);
        freq_error = 32'd0;
        tick();
        check("hold_recover", 64'(lock_state_out), 64'd2);
        freq_error = -32'sd21;
        repeat (3) tick();
        check("hold2_locked", 64'(locked_out), 64'd1);
        tick();
        check("unlock_state", 64'(lock_state_out), 64'd0);
        check("unlock_locked", 64'(locked_out), 64'd0);
        // statistics clear and snapshot
        freq_error = 32'd5;
        clear_stats_in = 1'b1;
        tick();
        clear_stats_in = 1'b0;
        snap_req_in = 1'b1;
        tick();
        snap_req_in = 1'b0;
        check("snap_clr_valid", 64'(snap_valid_out), 64'd1);
        check("snap_clr_data", snap_data_out, 64'h000003E8_00050005);
        snap_ack_in = 1'b1;
        tick();
        snap_ack_in = 1'b0;
        check("snap_clr_ack", 64'(snap_valid_out), 64'd0);
        // extremes
        freq_error = 32'h8000_0000;
        tick();
        check("min_int_state", 64'(lock_state_out), 64'd0);
        freq_error = 32'd100000;
        tick();
        freq_error = 32'd5;
        tick();
        snap_req_in = 1'b1;
        tick();
        snap_req_in = 1'b0;
        check("ext_valid", 64'(snap_valid_out), 64'd1);
        check("ext_data", snap_data_out, 64'h000003E8_80007FFF);
        // handshake: second request ignored, payload stable, ack drops valid
        freq_error = -32'sd7;
        PWM = 24'd500;
        repeat (2) tick();
        snap_req_in = 1'b1;
        tick();
        snap_req_in = 1'b0;
        check("hs_req2_valid", 64'(snap_valid_out), 64'd1);
        check("hs_req2_data", snap_data_out, 64'h000003E8_80007FFF);
        tick();
        snap_ack_in = 1'b1;
        tick();
        snap_ack_in = 1'b0;
        check("hs_ack", 64'(snap_valid_out), 64'd0);
        snap_req_in = 1'b1;
        tick();
        check("hs_new_valid", 64'(snap_valid_out), 64'd1);
        check("hs_new_data", snap_data_out, 64'h000001F4_80007FFF);
        snap_ack_in = 1'b1;
        tick();
        snap_req_in = 1'b0;
        snap_ack_in = 1'b0;
        check("hs_reqack", 64'(snap_valid_out), 64'd0);
        tick();
        check("hs_reqack_after", 64'(snap_valid_out), 64'd0);
        // rail detector
        PWM = 24'd32000;
        repeat (5) tick();
        check("rail_run1", 64'(rail_fault_out), 64'd0);
        PWM = 24'd31999;
        tick();
        check("rail_gap", 64'(rail_fault_out), 64'd0);
        PWM = 24'd32000;
        repeat (5) tick();
        check("rail_run2_5", 64'(rail_fault_out), 64'd0);
        tick();
        check("rail_run2_6", 64'(rail_fault_out), 64'd1);
        PWM = 24'd1000;
        repeat (2) tick();
        check("rail_sticky", 64'(rail_fault_out), 64'd1);
        clear_stats_in = 1'b1;
        tick();
        clear_stats_in = 1'b0;
        check("rail_clear", 64'(rail_fault_out), 64'd0);
        PWM = 24'd1;
        repeat (5) tick();
        check("rail_low_5", 64'(rail_fault_out), 64'd0);
        tick();
        check("rail_low_6", 64'(rail_fault_out), 64'd1);
        snap_req_in = 1'b1;
        tick();
        snap_req_in = 1'b0;
        check("rail_snap", snap_data_out, 64'h20000001_FFF9FFF9);
        snap_ack_in = 1'b1;
        PWM = 24'd1000;
        tick();
        snap_ack_in = 1'b0;
        // reset while in holdover with a snapshot pending
        freq_error = 32'd0;
        repeat (8) tick();
        check("relock", 64'(lock_state_out), 64'd2);
        freq_error = -32'sd21;
        snap_req_in = 1'b1;
        tick();
        snap_req_in = 1'b0;
        check("pre_rst_state", 64'(lock_state_out), 64'd3);
        check("pre_rst_data", snap_data_out, 64'hA00003E8_FFF90000);
        reset_in = 1'b1;
        freq_error = 32'd9;
        tick();
        check("mid_rst_locked", 64'(locked_out), 64'd0);
        check("mid_rst_state", 64'(lock_state_out), 64'd0);
        check("mid_rst_fault", 64'(rail_fault_out), 64'd0);
        check("mid_rst_valid", 64'(snap_valid_out), 64'd0);
        check("mid_rst_data", snap_data_out, 64'd0);
        reset_in = 1'b0;
        tick();
        snap_req_in = 1'b1;
        tick();
        snap_req_in = 1'b0;
        check("post_rst_data", snap_data_out, 64'h000003E8_00090009);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
